// File: rtl/board_vga_renderer_if.sv
// Board-state inputs and VGA outputs of the 4x4 board renderer.
// The game side (master) drives the board; the renderer (slave) drives the video pins.
interface board_vga_renderer_if;
  logic [63:0] cells;
  logic [3:0]  cursor;
  logic        cursor_en;
  logic [7:0]  R;
  logic [7:0]  G;
  logic [7:0]  B;
  logic        hsync;
  logic        vsync;
  logic        vgaclk;
  logic        frame_start;

  modport master (
    output cells, cursor, cursor_en,
    input  R, G, B, hsync, vsync, vgaclk, frame_start
  );

  modport slave (
    input  cells, cursor, cursor_en,
    output R, G, B, hsync, vsync, vgaclk, frame_start
  );
endinterface

// File: rtl/board_vga_renderer.sv
// VGA renderer for the 4x4 board: own raster timing from a /2 pixel enable, per-frame board
// snapshot, and a one-stage pixel pipeline drawing grid, pieces and cursor outline.
module board_vga_renderer #(
  parameter int unsigned HActive = 640,
  parameter int unsigned HFp     = 16,
  parameter int unsigned HSync   = 96,
  parameter int unsigned HBp     = 48,
  parameter int unsigned VActive = 480,
  parameter int unsigned VFp     = 10,
  parameter int unsigned VSync   = 2,
  parameter int unsigned VBp     = 33,
  parameter int unsigned CellPx  = 100,
  parameter int unsigned BoardX0 = 120,
  parameter int unsigned BoardY0 = 40,
  parameter int unsigned GridW   = 2,
  parameter int unsigned CurW    = 4
) (
  input logic               clk,
  input logic               rst,
  board_vga_renderer_if.slave bus_io
);

  localparam int unsigned HTotal  = HActive + HFp + HSync + HBp;
  localparam int unsigned VTotal  = VActive + VFp + VSync + VBp;
  localparam int unsigned HW      = $clog2(HTotal);
  localparam int unsigned VW      = $clog2(VTotal);
  localparam int unsigned HSyncLo = HActive + HFp;
  localparam int unsigned HSyncHi = HSyncLo + HSync;
  localparam int unsigned VSyncLo = VActive + VFp;
  localparam int unsigned VSyncHi = VSyncLo + VSync;
  localparam int unsigned BoardPx = 4 * CellPx;
  localparam int unsigned PieceLo = CellPx / 5;
  localparam int unsigned PieceHi = CellPx - PieceLo;

  localparam logic [23:0] ColCursor = 24'hFFFF00;
  localparam logic [23:0] ColGrid   = 24'hFFFFFF;
  localparam logic [23:0] ColRed    = 24'hFF0000;
  localparam logic [23:0] ColBlue   = 24'h0000FF;
  localparam logic [23:0] ColGreen  = 24'h00FF00;
  localparam logic [23:0] ColBg     = 24'h303030;

  logic          pix_en_q, vgaclk_q, frame_start_q;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [63:0]   snap_cells_q;
  logic [3:0]    snap_cursor_q;
  logic          snap_cur_en_q;
  logic [23:0]   rgb_q, rgb_d;
  logic          line_end, frame_end;

  always_comb begin
    line_end  = (h_cnt_q == HW'(HTotal - 1));
    frame_end = line_end && (v_cnt_q == VW'(VTotal - 1));
    h_cnt_d   = line_end ? '0 : h_cnt_q + 1'b1;
    v_cnt_d   = v_cnt_q;
    if (line_end) v_cnt_d = frame_end ? '0 : v_cnt_q + 1'b1;
  end

  int unsigned h, v, hx, vy, ox, oy;
  logic [1:0]  col, row;
  logic [3:0]  idx, code;
  logic        active, in_board, cur_hit, grid, piece;

  // Cell/offset decode by a compare-subtract chain; hx/vy wrap harmlessly left of/above the board.
  always_comb begin
    h  = 32'(h_cnt_q);
    v  = 32'(v_cnt_q);
    hx = h - BoardX0;
    vy = v - BoardY0;
    col = 2'd0;
    ox  = hx;
    if (hx >= 3 * CellPx) begin
      col = 2'd3;
      ox  = hx - 3 * CellPx;
    end else if (hx >= 2 * CellPx) begin
      col = 2'd2;
      ox  = hx - 2 * CellPx;
    end else if (hx >= CellPx) begin
      col = 2'd1;
      ox  = hx - CellPx;
    end
    row = 2'd0;
    oy  = vy;
    if (vy >= 3 * CellPx) begin
      row = 2'd3;
      oy  = vy - 3 * CellPx;
    end else if (vy >= 2 * CellPx) begin
      row = 2'd2;
      oy  = vy - 2 * CellPx;
    end else if (vy >= CellPx) begin
      row = 2'd1;
      oy  = vy - CellPx;
    end
    idx      = {row, col};
    code     = snap_cells_q[{idx, 2'b00} +: 4];
    active   = (h < HActive) && (v < VActive);
    in_board = (h >= BoardX0) && (h < BoardX0 + BoardPx) &&
               (v >= BoardY0) && (v < BoardY0 + BoardPx);
    cur_hit  = snap_cur_en_q && (idx == snap_cursor_q) &&
               ((ox < CurW) || (ox >= CellPx - CurW) || (oy < CurW) || (oy >= CellPx - CurW));
    grid     = (ox < GridW) || (oy < GridW) ||
               (h >= BoardX0 + BoardPx - GridW) || (v >= BoardY0 + BoardPx - GridW);
    piece    = (ox >= PieceLo) && (ox < PieceHi) && (oy >= PieceLo) && (oy < PieceHi);

    rgb_d = '0;
    if (active && in_board) begin
      if (cur_hit) begin
        rgb_d = ColCursor;
      end else if (grid) begin
        rgb_d = ColGrid;
      end else if (piece && (code != 4'd0)) begin
        case (code)
          4'd1:    rgb_d = ColRed;
          4'd2:    rgb_d = ColBlue;
          default: rgb_d = ColGreen;
        endcase
      end else begin
        rgb_d = ColBg;
      end
    end
    hsync_d = !((h >= HSyncLo) && (h < HSyncHi));
    vsync_d = !((v >= VSyncLo) && (v < VSyncHi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_en_q      <= 1'b0;
      vgaclk_q      <= 1'b0;
      frame_start_q <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      snap_cells_q  <= '0;
      snap_cursor_q <= '0;
      snap_cur_en_q <= 1'b0;
    end else begin
      pix_en_q      <= ~pix_en_q;
      vgaclk_q      <= pix_en_q;  // lags pix_en by one clk, i.e. its inverse once running
      frame_start_q <= pix_en_q && frame_end;
      if (pix_en_q) begin
        h_cnt_q <= h_cnt_d;
        v_cnt_q <= v_cnt_d;
        rgb_q   <= rgb_d;
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
        if (frame_end) begin
          snap_cells_q  <= bus_io.cells;
          snap_cursor_q <= bus_io.cursor;
          snap_cur_en_q <= bus_io.cursor_en;
        end
      end
    end
  end

  assign bus_io.R           = rgb_q[23:16];
  assign bus_io.G           = rgb_q[15:8];
  assign bus_io.B           = rgb_q[7:0];
  assign bus_io.hsync       = hsync_q;
  assign bus_io.vsync       = vsync_q;
  assign bus_io.vgaclk      = vgaclk_q;
  assign bus_io.frame_start = frame_start_q;

endmodule

// File: tb/tb_board_vga_renderer.sv
// Directed bench for board_vga_renderer on a scaled-down raster (80x55 total, 10 px cells)
// so that several whole frames fit in a short run.
module tb_board_vga_renderer;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;  // 80
  localparam int VT = VA + VF + VS + VB;  // 55
  localparam int FRAME_CLK = 2 * HT * VT; // 8800

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   ecnt = 0;
  int   hs_low = 0, vs_low = 0, fs_cnt = 0;
  int   mark;

  board_vga_renderer_if bus ();

  board_vga_renderer #(
    .HActive(HA), .HFp(HF), .HSync(HS), .HBp(HB),
    .VActive(VA), .VFp(VF), .VSync(VS), .VBp(VB),
    .CellPx(10), .BoardX0(12), .BoardY0(4), .GridW(1), .CurW(2)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
    if (bus.hsync === 1'b0) hs_low++;
    if (bus.vsync === 1'b0) vs_low++;
    if (bus.frame_start === 1'b1) fs_cnt++;
  endtask

  task automatic clr_win();
    hs_low = 0;
    vs_low = 0;
    fs_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic goto_edge(input int t);
    while (ecnt < t) tick();
  endtask

  // Pixel n = v*HT+h is on the outputs right after edge 2+2n (plus whole frames) since release.
  task automatic goto_px(input int h, input int v);
    int t;
    t = 2 + 2 * (v * HT + h);
    while (t < ecnt) t += FRAME_CLK;
    goto_edge(t);
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic [23:0] want);
    goto_px(h, v);
    chk(tag, {8'h00, bus.R, bus.G, bus.B}, {8'h00, want});
  endtask

  task automatic reset_checks(input string pfx);
    chk({pfx, "_rgb"}, {8'h00, bus.R, bus.G, bus.B}, 32'h0);
    chk({pfx, "_hsync"}, 32'(bus.hsync), 32'd1);
    chk({pfx, "_vsync"}, 32'(bus.vsync), 32'd1);
    chk({pfx, "_vgaclk"}, 32'(bus.vgaclk), 32'd0);
    chk({pfx, "_fstart"}, 32'(bus.frame_start), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.cells     = '0;
    bus.cursor    = 4'd0;
    bus.cursor_en = 1'b0;
    repeat (3) tick();
    reset_checks("rst");

    bus.cells[3:0]   = 4'd1;
    bus.cells[7:4]   = 4'd5;
    bus.cells[63:60] = 4'd2;
    bus.cursor       = 4'd15;
    rst  = 1'b0;
    ecnt = 0;
    clr_win();

    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("vgaclk_toggle", 32'(bus.vgaclk), 32'(ecnt % 2 == 0));
    end

    // Frame 0: snapshot still clear from reset.
    goto_px(67, 0); chk("hs_before", 32'(bus.hsync), 32'd1);
    goto_px(68, 0); chk("hs_first", 32'(bus.hsync), 32'd0);
    goto_px(75, 0); chk("hs_last", 32'(bus.hsync), 32'd0);
    goto_px(76, 0); chk("hs_after", 32'(bus.hsync), 32'd1);
    goto_px(0, 1);
    mark = hs_low;
    goto_px(0, 2);  chk("hs_line_clk", 32'(hs_low - mark), 32'(2 * HS));
    pix("f0_cell0_bg", 17, 9, 24'h303030);
    goto_px(79, 49); chk("vs_before", 32'(bus.vsync), 32'd1);
    goto_px(0, 50);  chk("vs_first", 32'(bus.vsync), 32'd0);
    goto_px(79, 51); chk("vs_last", 32'(bus.vsync), 32'd0);
    goto_px(0, 52);  chk("vs_after", 32'(bus.vsync), 32'd1);
    goto_edge(FRAME_CLK);
    chk("fstart_pulse", 32'(bus.frame_start), 32'd1);
    chk("fstart_count", 32'(fs_cnt), 32'd1);
    chk("vs_frame_clk", 32'(vs_low), 32'(2 * HT * VS));
    chk("hs_frame_clk", 32'(hs_low), 32'(2 * HS * VT));
    tick();
    chk("fstart_one_clk", 32'(bus.frame_start), 32'd0);

    // Frame 1: board visible, cursor disabled in the snapshot.
    pix("grid_corner", 12, 4, 24'hFFFFFF);
    bus.cursor_en = 1'b1;
    pix("outside_board", 5, 5, 24'h000000);
    pix("cell_bg", 13, 5, 24'h303030);
    pix("piece_red", 17, 9, 24'hFF0000);
    pix("piece_green", 27, 9, 24'h00FF00);
    pix("grid_outer", 51, 10, 24'hFFFFFF);
    pix("hblank", 70, 10, 24'h000000);
    pix("right_of_board", 60, 30, 24'h000000);
    pix("cur_not_yet", 42, 34, 24'hFFFFFF);
    pix("piece_blue", 47, 39, 24'h0000FF);

    // Frame 2: cursor on cell 15; a mid-frame board change must wait for the next frame.
    goto_px(0, 20);
    bus.cells[35:32] = 4'd1;
    pix("midframe_hold", 17, 29, 24'h303030);
    pix("cursor_tl", 42, 34, 24'hFFFF00);
    pix("cursor_blue", 47, 39, 24'h0000FF);
    pix("cursor_br", 51, 43, 24'hFFFF00);

    // Frame 3: the change shows; then a one-clk reset mid-frame.
    pix("midframe_next", 17, 29, 24'hFF0000);
    goto_px(0, 30);
    rst = 1'b1;
    tick();
    reset_checks("midrst");
    rst  = 1'b0;
    ecnt = 0;
    clr_win();
    goto_px(67, 0); chk("rst_hs_before", 32'(bus.hsync), 32'd1);
    goto_px(68, 0); chk("rst_hs_first", 32'(bus.hsync), 32'd0);
    pix("rst_snap_clear", 17, 9, 24'h303030);
    goto_edge(FRAME_CLK - 1);
    chk("rst_fstart_early", 32'(fs_cnt), 32'd0);
    tick();
    chk("rst_fstart_pulse", 32'(bus.frame_start), 32'd1);
    chk("rst_vs_frame_clk", 32'(vs_low), 32'(2 * HT * VS));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
